// File: rtl/prbs_frame_gen.sv
`default_nettype none
// ============================================================================
// prbs_frame_gen : framed PRBS (7/15/23/31) stream source with ready/valid
//                  handshake. Optional error injection: PRBS_FRAME_GEN_ERR_INJ_EN
// Revision: 1.0
// ============================================================================
module prbs_frame_gen #(
    parameter int DATA_W      = 32,
    parameter int POLY        = 31,
    parameter int FRAME_BEATS = 256,
    parameter int INV_PATTERN = 1
) (
    input  logic                  tx_user_clk_i,
    input  logic                  tx_user_rst_n_i,
    input  logic                  en_i,
    input  logic [15:0]           num_frames_i,
    input  logic                  inj_err_i,
    output logic [DATA_W-1:0]     tx_data_o,
    output logic [DATA_W/8-1:0]   tx_vldb_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  tx_last_o,
    output logic                  tx_user_o,
    output logic                  busy_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int TAP = (POLY == 7)  ? 6  :
                         (POLY == 15) ? 14 :
                         (POLY == 23) ? 18 : 28;
    localparam int BEAT_W = (FRAME_BEATS > 2) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);
    localparam logic [DATA_W-1:0] INV_MASK  = (INV_PATTERN != 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [POLY-1:0]     lfsr, lfsr_adv, shreg;
    logic [DATA_W-1:0]   word, data_q;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [15:0]         frame_cnt, frames_tgt, frame_inc;
    logic                accept, start, load, at_last, flip_bit, nb;

    assign start     = (state == IDLE) && en_i;
    assign accept    = (state == RUN) && tx_ready_i;
    assign load      = start || accept;
    assign at_last   = (beat_cnt == LAST_BEAT);
    assign frame_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;

    // Each load consumes DATA_W bit-steps; a fresh run always begins from all ones.
    always_comb begin
        shreg = (state == IDLE) ? {POLY{1'b1}} : lfsr;
        word  = '0;
        nb    = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            nb      = shreg[POLY-1] ^ shreg[TAP-1];
            word[i] = nb;
            shreg   = {shreg[POLY-2:0], nb};
        end
        lfsr_adv = shreg;
    end

    always_comb begin
        state_nxt  = state;
        tx_valid_o = 1'b0;
        busy_o     = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (en_i) state_nxt = RUN;
            end
            RUN: begin
                tx_valid_o = 1'b1;
                if (accept && at_last) begin
                    if ((frames_tgt != 16'd0) && (frame_inc == frames_tgt))
                        state_nxt = DONE;
                    else if (!en_i)
                        state_nxt = IDLE;
                end
            end
            DONE: begin
                if (!en_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
        if (!tx_user_rst_n_i) begin
            state      <= IDLE;
            lfsr       <= {POLY{1'b1}};
            data_q     <= '0;
            beat_cnt   <= '0;
            frame_cnt  <= '0;
            frames_tgt <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                frames_tgt <= num_frames_i;
                frame_cnt  <= '0;
                beat_cnt   <= '0;
            end else if (accept) begin
                beat_cnt <= at_last ? '0 : beat_cnt + BEAT_W'(1);
                if (at_last) frame_cnt <= frame_inc;
            end
            if (load) begin
                lfsr   <= lfsr_adv;
                data_q <= (word ^ INV_MASK) ^ {{(DATA_W-1){1'b0}}, flip_bit};
            end
        end
    end

`ifdef PRBS_FRAME_GEN_ERR_INJ_EN
    logic inj_pend, user_q;

    // A request arriving on a load cycle is held for the following load.
    always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
        if (!tx_user_rst_n_i) begin
            inj_pend <= 1'b0;
            user_q   <= 1'b0;
        end else if (load) begin
            user_q   <= inj_pend;
            inj_pend <= inj_err_i;
        end else if (inj_err_i) begin
            inj_pend <= 1'b1;
        end
    end

    assign flip_bit  = inj_pend;
    assign tx_user_o = user_q;
`else
    logic unused_inj;
    assign unused_inj = inj_err_i;
    assign flip_bit   = 1'b0;
    assign tx_user_o  = 1'b0;
`endif

    assign tx_data_o   = data_q;
    assign tx_last_o   = at_last;
    assign tx_vldb_o   = {(DATA_W/8){tx_valid_o}};
    assign frame_cnt_o = frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_frame_gen.sv
`default_nettype none
// ============================================================================
// tb_prbs_frame_gen : directed self-checking bench for prbs_frame_gen
// Revision: 1.0
// ============================================================================
module tb_prbs_frame_gen;

    localparam int DW  = 32;
    localparam int FB  = 4;
    localparam int DW7 = 16;
    localparam int FB7 = 5;
    localparam int N7  = 1000;
`ifdef PRBS_FRAME_GEN_ERR_INJ_EN
    localparam logic INJ = 1'b1;
`else
    localparam logic INJ = 1'b0;
`endif

    logic            clk, rst_n;
    logic            en, ready, inj, en7, ready7;
    logic [15:0]     nf, nf7;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] vldb;
    logic            valid, last, user, busy;
    logic [15:0]     fcnt;
    logic [DW7-1:0]  data7;
    logic [DW7/8-1:0] vldb7;
    logic            valid7, last7, user7, busy7;
    logic [15:0]     fcnt7;

    int checks   = 0;
    int failures = 0;

    bit m31 [0:1023];
    bit m7  [0:16031];
    bit stream7 [0:DW7*N7-1];

    prbs_frame_gen #(.DATA_W(DW), .POLY(31), .FRAME_BEATS(FB), .INV_PATTERN(1)) dut (
        .tx_user_clk_i(clk), .tx_user_rst_n_i(rst_n), .en_i(en), .num_frames_i(nf),
        .inj_err_i(inj), .tx_data_o(data), .tx_vldb_o(vldb), .tx_valid_o(valid),
        .tx_ready_i(ready), .tx_last_o(last), .tx_user_o(user), .busy_o(busy),
        .frame_cnt_o(fcnt)
    );

    prbs_frame_gen #(.DATA_W(DW7), .POLY(7), .FRAME_BEATS(FB7), .INV_PATTERN(0)) dut7 (
        .tx_user_clk_i(clk), .tx_user_rst_n_i(rst_n), .en_i(en7), .num_frames_i(nf7),
        .inj_err_i(1'b0), .tx_data_o(data7), .tx_vldb_o(vldb7), .tx_valid_o(valid7),
        .tx_ready_i(ready7), .tx_last_o(last7), .tx_user_o(user7), .busy_o(busy7),
        .frame_cnt_o(fcnt7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Golden stream as a recurrence: out[n] = out[n-P] ^ out[n-T], with P ones before n=0.
    function automatic logic [DW-1:0] w31(input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = m31[31 + k*DW + i];
        return ~r;
    endfunction

    function automatic logic [DW7-1:0] w7(input int k);
        logic [DW7-1:0] r;
        for (int i = 0; i < DW7; i++) r[i] = m7[7 + k*DW7 + i];
        return r;
    endfunction

    initial begin
        int mis;
        for (int i = 0; i < 31; i++) m31[i] = 1'b1;
        for (int j = 31; j < 1024; j++) m31[j] = m31[j-31] ^ m31[j-28];
        for (int i = 0; i < 7; i++) m7[i] = 1'b1;
        for (int j = 7; j < 16032; j++) m7[j] = m7[j-7] ^ m7[j-6];

        rst_n = 1'b0; en = 1'b0; ready = 1'b1; nf = 16'd2; inj = 1'b0;
        en7 = 1'b0; ready7 = 1'b1; nf7 = 16'd0;
        repeat (3) @(negedge clk);

        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_vldb", vldb, 0);
        check("rst_last", last, 0);
        check("rst_user", user, 0);
        check("rst_busy", busy, 0);
        check("rst_fcnt", fcnt, 0);
        check("rst_valid7", valid7, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        en = 1'b1;
        @(negedge clk);
        check("seed_word_hand", data, 32'h8FFF_FFFF);

        // Two 4-beat frames, then DONE
        for (int b = 0; b < 8; b++) begin
            check("run_valid", valid, 1);
            check("run_vldb", vldb, 4'hF);
            check("run_data", data, w31(b));
            check("run_last", last, (b % FB) == FB - 1);
            check("run_fcnt", fcnt, b / FB);
            @(negedge clk);
        end
        check("done_valid", valid, 0);
        check("done_vldb", vldb, 0);
        check("done_busy", busy, 1);
        check("done_fcnt", fcnt, 2);
        @(negedge clk);
        check("done_hold_fcnt", fcnt, 2);
        check("done_hold_valid", valid, 0);
        en = 1'b0;
        @(negedge clk);
        check("done_to_idle", busy, 0);

        // Stall on beat 1; num_frames change mid-run must be ignored
        en = 1'b1;
        @(negedge clk);
        check("stall_b0", data, w31(0));
        @(negedge clk);
        ready = 1'b0;
        nf = 16'd1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_data", data, w31(1));
            check("stall_last", last, 0);
            check("stall_valid", valid, 1);
        end
        ready = 1'b1;
        for (int b = 1; b < 8; b++) begin
            check("post_stall_data", data, w31(b));
            check("post_stall_last", last, (b % FB) == FB - 1);
            @(negedge clk);
        end
        check("nf_ignored_valid", valid, 0);
        check("nf_ignored_fcnt", fcnt, 2);
        en = 1'b0;
        @(negedge clk);

        // en dropped mid-frame: frame completes, then IDLE
        nf = 16'd0;
        en = 1'b1;
        @(negedge clk);
        check("drop_b0", data, w31(0));
        @(negedge clk);
        en = 1'b0;
        for (int b = 1; b < 4; b++) begin
            check("drop_valid", valid, 1);
            check("drop_data", data, w31(b));
            check("drop_last", last, b == 3);
            @(negedge clk);
        end
        check("drop_idle_valid", valid, 0);
        check("drop_idle_busy", busy, 0);
        check("drop_fcnt", fcnt, 1);
        en = 1'b1;
        @(negedge clk);
        check("reenable_seed", data, w31(0));
        check("reenable_valid", valid, 1);

        // Asynchronous reset at beat 2 of the second frame
        repeat (6) @(negedge clk);
        check("pre_rst_data", data, w31(6));
        check("pre_rst_fcnt", fcnt, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_fcnt", fcnt, 0);
        check("async_rst_data", data, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_seed", data, w31(0));
        check("restart_fcnt", fcnt, 0);
        check("restart_last", last, 0);

        // Injection pulses during a stall on beat 5
        repeat (5) @(negedge clk);
        check("inj_b5_data", data, w31(5));
        check("inj_b5_user", user, 0);
        ready = 1'b0;
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        check("inj_stall_data", data, w31(5));
        check("inj_stall_user", user, 0);
        ready = 1'b1;
        @(negedge clk);
        check("inj_b6_data", data, w31(6) ^ {{(DW-1){1'b0}}, INJ});
        check("inj_b6_user", user, INJ);
        @(negedge clk);
        check("inj_b7_data", data, w31(7));
        check("inj_b7_user", user, 0);
        en = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("stop_to_idle", busy, 0);

        // PRBS7, 16-bit, continuous, 5-beat frames
        en7 = 1'b1;
        @(negedge clk);
        check("p7_seed_hand", data7, 16'h3040);
        for (int k = 0; k < N7; k++) begin
            check("p7_valid", valid7, 1);
            check("p7_data", data7, w7(k));
            check("p7_last", last7, (k % FB7) == FB7 - 1);
            for (int i = 0; i < DW7; i++) stream7[k*DW7 + i] = data7[i];
            @(negedge clk);
        end
        check("p7_fcnt", fcnt7, N7 / FB7);
        mis = 0;
        for (int i = 0; i + 127 < DW7*N7; i++)
            if (stream7[i] != stream7[i+127]) mis++;
        check("p7_period127", mis, 0);
        en7 = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
